vga_text_sched: RTL and testbench

VGA_TEXT_SCHED -- requirements
Module: vga_text_sched

---
 rtl/vga_text_sched.sv | 137 +++++++++++++
 tb/tb_vga_text_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_sched.sv
// Text-row prefetch scheduler: shares one text-RAM port between row prefetch into a
// double-buffered line store and host character writes, with display reads taking priority.
module vga_text_sched #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CODE_W = 8
) (
    input  logic                CLK_25,
    input  logic                RST,
    input  logic                LINE_START,
    input  logic [3:0]          ROW_SEL,
    input  logic                HOST_VALID,
    output logic                HOST_READY,
    input  logic [4+ADDR_W-1:0] HOST_ADDR,
    input  logic [CODE_W-1:0]   HOST_DATA,
    output logic [4+ADDR_W-1:0] RAM_ADDR,
    output logic                RAM_WE,
    output logic [CODE_W-1:0]   RAM_WDATA,
    input  logic [CODE_W-1:0]   RAM_RDATA,
    input  logic [ADDR_W-1:0]   CHAR_IDX,
    output logic [CODE_W-1:0]   CHAR_CODE,
    output logic                FETCH_DONE,
    output logic                OVERRUN,
    input  logic                CLR_OVR
);

    localparam int unsigned N = 2 ** ADDR_W;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [3:0]        row_q, row_d;
    logic              act_sel_q, act_sel_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;
    logic [CODE_W-1:0] char_q;
    logic [CODE_W-1:0] buf_q [2][N];

    logic              shadow_we;
    logic [ADDR_W-1:0] shadow_idx;
    logic              shadow_sel;
    logic              host_ok;

    assign shadow_sel = ~act_sel_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        act_sel_d  = act_sel_q;
        done_d     = 1'b0;
        shadow_we  = 1'b0;
        shadow_idx = cnt_q - 1'b1;
        case (state_q)
            StIdle: begin
                if (LINE_START) begin
                    row_d   = ROW_SEL;
                    cnt_d   = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                // Read data lags the address by one cycle, so cell cnt-1 lands now.
                shadow_we = (cnt_q != '0);
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                shadow_we  = 1'b1;
                shadow_idx = {ADDR_W{1'b1}};
                state_d    = StIdle;
                act_sel_d  = ~act_sel_q;
                done_d     = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        ovr_d = ovr_q;
        if (CLR_OVR) begin
            ovr_d = 1'b0;
        end
        if (LINE_START && (state_q != StIdle)) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge CLK_25) begin
        if (RST) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            row_q     <= '0;
            act_sel_q <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            char_q    <= '0;
            for (int i = 0; i < N; i++) begin
                buf_q[0][i] <= '0;
                buf_q[1][i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            act_sel_q <= act_sel_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            char_q    <= buf_q[act_sel_q][CHAR_IDX];
            if (shadow_we) begin
                buf_q[shadow_sel][shadow_idx] <= RAM_RDATA;
            end
        end
    end

    // Outputs are forced low combinationally so they hold their idle values throughout reset.
    always_comb begin
        host_ok    = (state_q == StIdle) && !LINE_START && !RST;
        HOST_READY = host_ok;
        RAM_WE     = host_ok && HOST_VALID;
        RAM_ADDR   = '0;
        RAM_WDATA  = '0;
        if (RAM_WE) begin
            RAM_ADDR  = HOST_ADDR;
            RAM_WDATA = HOST_DATA;
        end else if ((state_q == StFetch) && !RST) begin
            RAM_ADDR = {row_q, cnt_q};
        end
        CHAR_CODE  = RST ? '0 : char_q;
        FETCH_DONE = done_q && !RST;
        OVERRUN    = ovr_q && !RST;
    end

endmodule

// File: tb/tb_vga_text_sched.sv
// Directed-plus-random bench for vga_text_sched with a behavioural text-RAM and row-buffer model.
module tb_vga_text_sched;

    localparam int N = 16;

    logic       CLK_25 = 1'b0;
    logic       RST = 1'b1;
    logic       LINE_START = 1'b0;
    logic [3:0] ROW_SEL = '0;
    logic       HOST_VALID = 1'b0;
    logic       HOST_READY;
    logic [7:0] HOST_ADDR = '0;
    logic [7:0] HOST_DATA = '0;
    logic [7:0] RAM_ADDR;
    logic       RAM_WE;
    logic [7:0] RAM_WDATA;
    logic [7:0] RAM_RDATA = '0;
    logic [3:0] CHAR_IDX = '0;
    logic [7:0] CHAR_CODE;
    logic       FETCH_DONE;
    logic       OVERRUN;
    logic       CLR_OVR = 1'b0;

    logic [7:0] ram [256] = '{default: 8'h00};
    logic [7:0] exp_mem [256] = '{default: 8'h00};
    logic [7:0] active_exp [N] = '{default: 8'h00};
    bit         ovr_exp = 1'b0;
    int         tests = 0;
    int         fails = 0;

    vga_text_sched #(.ADDR_W(4), .CODE_W(8)) dut (
        .CLK_25    (CLK_25),
        .RST       (RST),
        .LINE_START(LINE_START),
        .ROW_SEL   (ROW_SEL),
        .HOST_VALID(HOST_VALID),
        .HOST_READY(HOST_READY),
        .HOST_ADDR (HOST_ADDR),
        .HOST_DATA (HOST_DATA),
        .RAM_ADDR  (RAM_ADDR),
        .RAM_WE    (RAM_WE),
        .RAM_WDATA (RAM_WDATA),
        .RAM_RDATA (RAM_RDATA),
        .CHAR_IDX  (CHAR_IDX),
        .CHAR_CODE (CHAR_CODE),
        .FETCH_DONE(FETCH_DONE),
        .OVERRUN   (OVERRUN),
        .CLR_OVR   (CLR_OVR)
    );

    always #5 CLK_25 = ~CLK_25;

    // Synchronous text RAM: one-cycle read latency on the shared port.
    always @(posedge CLK_25) begin
        if (RAM_WE) ram[RAM_ADDR] <= RAM_WDATA;
        RAM_RDATA <= ram[RAM_ADDR];
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(negedge CLK_25);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, HOST_READY, 0);
        chk({tag, "_we"}, RAM_WE, 0);
        chk({tag, "_addr"}, RAM_ADDR, 0);
        chk({tag, "_wdata"}, RAM_WDATA, 0);
        chk({tag, "_char"}, CHAR_CODE, 0);
        chk({tag, "_done"}, FETCH_DONE, 0);
        chk({tag, "_ovr"}, OVERRUN, 0);
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        cyc();
        HOST_VALID = 1'b1;
        HOST_ADDR  = a;
        HOST_DATA  = d;
        #1;
        chk("hw_ready", HOST_READY, 1);
        chk("hw_we", RAM_WE, 1);
        chk("hw_addr", RAM_ADDR, a);
        chk("hw_wdata", RAM_WDATA, d);
        exp_mem[a] = d;
        cyc();
        HOST_VALID = 1'b0;
    endtask

    // One full prefetch of a row; optional second LINE_START (with or without CLR_OVR)
    // and an optional host write presented in the same cycle as the first LINE_START.
    task automatic do_fetch(input logic [3:0] row, input int ls2_at, input bit clr_with,
                            input bit hv, input logic [7:0] ha, input logic [7:0] hd);
        logic [7:0] snap [N];
        for (int i = 0; i < N; i++) snap[i] = exp_mem[{row, 4'(i)}];
        cyc();
        LINE_START = 1'b1;
        ROW_SEL    = row;
        HOST_VALID = hv;
        HOST_ADDR  = ha;
        HOST_DATA  = hd;
        #1;
        chk("ls_ready", HOST_READY, 0);
        chk("ls_we", RAM_WE, 0);
        for (int k = 1; k <= N + 2; k++) begin
            cyc();
            LINE_START = (k == ls2_at);
            CLR_OVR    = (k == ls2_at) && clr_with;
            ROW_SEL    = 4'($urandom);
            #1;
            if (k <= N) chk("fetch_addr", RAM_ADDR, {row, 4'(k - 1)});
            if (k < N + 2) begin
                chk("fetch_ready", HOST_READY, 0);
                chk("fetch_we", RAM_WE, 0);
            end else begin
                chk("idle_ready", HOST_READY, 1);
                chk("idle_we", RAM_WE, hv);
                if (hv) begin
                    chk("arb_addr", RAM_ADDR, ha);
                    chk("arb_wdata", RAM_WDATA, hd);
                end
            end
            chk("fetch_done", FETCH_DONE, k == N + 2);
            chk("overrun", OVERRUN, ovr_exp);
            if (k == ls2_at) ovr_exp = 1'b1;
        end
        cyc();
        LINE_START = 1'b0;
        CLR_OVR    = 1'b0;
        HOST_VALID = 1'b0;
        if (hv) exp_mem[ha] = hd;
        for (int i = 0; i < N; i++) active_exp[i] = snap[i];
        #1;
        chk("done_pulse", FETCH_DONE, 0);
    endtask

    task automatic check_chars();
        for (int i = 0; i < N; i++) begin
            cyc();
            CHAR_IDX = 4'(i);
            cyc();
            #1;
            chk("char_code", CHAR_CODE, active_exp[i]);
        end
    endtask

    initial begin
        logic [7:0] ha, hd;

        // Reset with a host request pending: nothing may be accepted.
        HOST_VALID = 1'b1;
        HOST_ADDR  = 8'h12;
        HOST_DATA  = 8'h99;
        cyc();
        cyc();
        #1;
        chk_reset_outs("reset");
        cyc();
        HOST_VALID = 1'b0;
        RST        = 1'b0;
        #1;
        chk("post_reset_ready", HOST_READY, 1);
        chk("post_reset_char", CHAR_CODE, 0);

        for (int i = 0; i < N; i++) host_write({4'd3, 4'(i)}, 8'(8'h41 + i));

        // Reset in the middle of a prefetch.
        cyc();
        LINE_START = 1'b1;
        ROW_SEL    = 4'd3;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            LINE_START = 1'b0;
        end
        cyc();
        RST      = 1'b1;
        CHAR_IDX = 4'd5;
        #1;
        chk_reset_outs("midrst");
        cyc();
        #1;
        chk_reset_outs("midrst2");
        cyc();
        RST     = 1'b0;
        ovr_exp = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            #1;
            chk("rst_no_done", FETCH_DONE, 0);
            chk("rst_idle_ready", HOST_READY, 1);
        end
        check_chars();

        // Basic fetch of row 3.
        do_fetch(4'd3, -1, 1'b0, 1'b0, 8'h00, 8'h00);
        check_chars();

        // Active-row isolation.
        host_write(8'h35, 8'h7E);
        check_chars();
        do_fetch(4'd3, -1, 1'b0, 1'b0, 8'h00, 8'h00);
        check_chars();

        // Arbitration: host write coincides with LINE_START.
        ha = 8'($urandom_range(8'h40, 8'hFF));
        hd = 8'($urandom);
        do_fetch(4'd3, -1, 1'b0, 1'b1, ha, hd);
        do_fetch(ha[7:4], -1, 1'b0, 1'b0, 8'h00, 8'h00);
        check_chars();

        // Overrun, then clear; then set coinciding with clear.
        do_fetch(4'd3, 7, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("ovr_set", OVERRUN, 1);
        cyc();
        CLR_OVR = 1'b1;
        #1;
        chk("ovr_hold", OVERRUN, 1);
        cyc();
        CLR_OVR = 1'b0;
        ovr_exp = 1'b0;
        #1;
        chk("ovr_clr", OVERRUN, 0);
        do_fetch(4'd3, 7, 1'b1, 1'b0, 8'h00, 8'h00);
        chk("ovr_set_wins", OVERRUN, 1);
        cyc();
        CLR_OVR = 1'b1;
        cyc();
        CLR_OVR = 1'b0;
        ovr_exp = 1'b0;
        #1;
        chk("ovr_clr2", OVERRUN, 0);

        // Back-to-back host stream into rows 0 and 1.
        cyc();
        HOST_VALID = 1'b1;
        for (int j = 0; j < 2 * N; j++) begin
            if (j > 0) cyc();
            HOST_ADDR = 8'(j);
            HOST_DATA = 8'($urandom);
            #1;
            chk("b2b_we", RAM_WE, 1);
            chk("b2b_addr", RAM_ADDR, j);
            chk("b2b_wdata", RAM_WDATA, HOST_DATA);
            exp_mem[j] = HOST_DATA;
        end
        cyc();
        HOST_VALID = 1'b0;
        for (int j = 0; j < 2 * N; j++) chk("b2b_ram", ram[j], exp_mem[j]);
        do_fetch(4'd0, -1, 1'b0, 1'b0, 8'h00, 8'h00);
        check_chars();
        do_fetch(4'd1, -1, 1'b0, 1'b0, 8'h00, 8'h00);
        check_chars();

        // A few random rows.
        for (int r = 0; r < 3; r++) begin
            do_fetch(4'($urandom_range(0, 15)), -1, 1'b0, 1'b0, 8'h00, 8'h00);
            check_chars();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
